// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
//   Direct-mapped branch target buffer for the fetch stage. A fetch PC is
//   looked up combinationally. The stored target is returned on a hit, so
//   fetch can redirect before decode. Entries are trained from the EX-stage
//   branch result. A multi-cycle invalidate sweep clears every entry.
//
//   Field split: index = pc[INDEX_BITS+1:2], tag = pc[ADDR_W-1:INDEX_BITS+2].
//   pc[1:0] is ignored.
//
// Parameters
//   INDEX_BITS    log2 of entry count (2..10)
//   ADDR_W        PC / target width
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_lkp_pc          fetch PC to look up
//   o_lkp_hit         valid entry with matching tag (combinational)
//   o_lkp_target      stored target, 0 on a miss
//   i_upd_valid       EX branch result valid
//   i_upd_pc          PC of the resolved branch/jump
//   i_upd_target      resolved target
//   i_upd_outcome     branch outcome; 1 = TAKEN, 0 = NOT_TAKEN
//                     (encoding of mips_core_pkg::BranchOutcome)
//   i_flush           single-cycle pulse that starts or restarts the sweep
//   o_busy            sweep in progress
//
// Optional feature (macro BTB_STATS_EN)
//   o_stat_lookups, o_stat_hits, o_stat_evicts are saturating 32-bit
//   counters. i_flush does not clear them.
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_target_buffer #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned ADDR_W     = `ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_lkp_pc,
  output logic              o_lkp_hit,
  output logic [ADDR_W-1:0] o_lkp_target,
  input  logic              i_upd_valid,
  input  logic [ADDR_W-1:0] i_upd_pc,
  input  logic [ADDR_W-1:0] i_upd_target,
  input  logic              i_upd_outcome,
  input  logic              i_flush,
`ifdef BTB_STATS_EN
  output logic [31:0]       o_stat_lookups,
  output logic [31:0]       o_stat_hits,
  output logic [31:0]       o_stat_evicts,
`endif
  output logic              o_busy
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W   = ADDR_W - INDEX_BITS - 2;
  localparam int unsigned CNT_W   = INDEX_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENTRIES - 1);
  localparam logic OUTCOME_TAKEN = 1'b1;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [ADDR_W-1:0]  tgt_mem [ENTRIES];

  logic [INDEX_BITS-1:0] lkp_idx, upd_idx, sweep_idx;
  logic [TAG_W-1:0]      lkp_tag, upd_tag;
  logic                  upd_en, upd_taken, upd_tag_match;

  // pc[1:0] never participates in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{i_lkp_pc[1:0], i_upd_pc[1:0]};

  assign lkp_idx   = i_lkp_pc[INDEX_BITS+1:2];
  assign lkp_tag   = i_lkp_pc[ADDR_W-1:INDEX_BITS+2];
  assign upd_idx   = i_upd_pc[INDEX_BITS+1:2];
  assign upd_tag   = i_upd_pc[ADDR_W-1:INDEX_BITS+2];
  assign sweep_idx = cnt_q[INDEX_BITS-1:0];

  assign o_busy = (state_q == FLUSH);

  // Lookup sees pre-update contents; there is no bypass from the update port.
  assign o_lkp_hit    = valid_q[lkp_idx] & (tag_mem[lkp_idx] == lkp_tag) & ~o_busy;
  assign o_lkp_target = o_lkp_hit ? tgt_mem[lkp_idx] : '0;

  // Updates are accepted only in IDLE. A flush in the same cycle takes priority.
  assign upd_en        = (state_q == IDLE) & i_upd_valid & ~i_flush;
  assign upd_taken     = (i_upd_outcome == OUTCOME_TAKEN);
  assign upd_tag_match = (tag_mem[upd_idx] == upd_tag);

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_flush) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        if (i_flush) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (state_q == FLUSH) begin
      valid_q[sweep_idx] <= 1'b0;
    end else if (upd_en) begin
      if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
      end else if (upd_tag_match) begin
        valid_q[upd_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) begin
      tag_mem[upd_idx] <= upd_tag;
      tgt_mem[upd_idx] <= i_upd_target;
    end
  end

`ifdef BTB_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  logic evict_ev;
  assign evict_ev = upd_en & upd_taken & valid_q[upd_idx] & ~upd_tag_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stat_lookups <= '0;
      o_stat_hits    <= '0;
      o_stat_evicts  <= '0;
    end else begin
      if ((state_q == IDLE) && (o_stat_lookups != '1)) o_stat_lookups <= o_stat_lookups + 1'b1;
      if (o_lkp_hit && (o_stat_hits != '1))            o_stat_hits    <= o_stat_hits + 1'b1;
      if (evict_ev && (o_stat_evicts != '1))           o_stat_evicts  <= o_stat_evicts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  logic        clk;
  logic        rst_n;
  logic [31:0] lkp_pc;
  logic        lkp_hit;
  logic [31:0] lkp_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_outcome;
  logic        flush;
  logic        busy;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_evicts;
`endif

  int checks = 0;
  int errors = 0;

  branch_target_buffer #(.INDEX_BITS(6), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_lkp_pc      (lkp_pc),
    .o_lkp_hit     (lkp_hit),
    .o_lkp_target  (lkp_target),
    .i_upd_valid   (upd_valid),
    .i_upd_pc      (upd_pc),
    .i_upd_target  (upd_target),
    .i_upd_outcome (upd_outcome),
    .i_flush       (flush),
`ifdef BTB_STATS_EN
    .o_stat_lookups(stat_lookups),
    .o_stat_hits   (stat_hits),
    .o_stat_evicts (stat_evicts),
`endif
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] lkp_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_out;
    logic        exp_hit;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    upd_valid   = 1'b0;
    upd_pc      = '0;
    upd_target  = '0;
    upd_outcome = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_outcome = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic probe(input string nm, input logic [31:0] pc, input logic eh, input logic [31:0] et);
    lkp_pc = pc;
    #1;
    check({nm, "_hit"}, 32'(lkp_hit), 32'(eh));
    check({nm, "_tgt"}, lkp_target, et);
  endtask

  // Pulse flush, then count busy cycles; optionally re-pulse flush at
  // observed cycle restart_at and/or issue an update at cycle upd_at.
  task automatic sweep(input string nm, input int restart_at, input int upd_at,
                       input int exp_cycles);
    int n;
    int hit_bad;
    n = 0;
    hit_bad = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    while (busy && n < 200) begin
      n++;
      case (n % 3)
        0: lkp_pc = 32'h0040_0000;
        1: lkp_pc = 32'h0040_007C;
        default: lkp_pc = 32'h0040_00FC;
      endcase
      if (n == restart_at) flush = 1'b1;
      if (n == upd_at) begin
        upd_valid = 1'b1; upd_pc = 32'h0040_0040; upd_target = 32'h0040_0999; upd_outcome = 1'b1;
      end
      #1;
      if (lkp_hit !== 1'b0 || lkp_target !== 32'h0) hit_bad++;
      tick();
      idle_inputs();
    end
    check({nm, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    check({nm, "_miss_during"}, 32'(hit_bad), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"reset_lkp",   32'h0040_0010, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0};
    vecs[1]  = '{"same_cycle",  32'h0040_0010, 1'b1, 32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{"next_cycle",  32'h0040_0010, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0040_0100};
    vecs[3]  = '{"alias_upd",   32'h0040_0110, 1'b1, 32'h0040_0110, 32'h0040_0200, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{"alias_old",   32'h0040_0010, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0};
    vecs[5]  = '{"alias_new",   32'h0040_0110, 1'b1, 32'h0040_0010, 32'h0,         1'b0, 1'b1, 32'h0040_0200};
    vecs[6]  = '{"nt_mismatch", 32'h0040_0110, 1'b1, 32'h0040_0110, 32'h0,         1'b0, 1'b1, 32'h0040_0200};
    vecs[7]  = '{"nt_evicted",  32'h0040_0110, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0};
    vecs[8]  = '{"lsb_upd",     32'h0040_0017, 1'b1, 32'h0040_0014, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{"lsb_ignored", 32'h0040_0017, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h1234_5678};
    vecs[10] = '{"other_idx",   32'h0040_0018, 1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0};

    rst_n  = 1'b0;
    lkp_pc = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    check("reset_busy", 32'(busy), 32'd0);

    // Each vector: drive inputs, check the combinational lookup before the edge.
    for (int i = 0; i < 11; i++) begin
      lkp_pc      = vecs[i].lkp_pc;
      upd_valid   = vecs[i].upd_valid;
      upd_pc      = vecs[i].upd_pc;
      upd_target  = vecs[i].upd_target;
      upd_outcome = vecs[i].upd_out;
      #1;
      check({vecs[i].name, "_hit"}, 32'(lkp_hit), 32'(vecs[i].exp_hit));
      check({vecs[i].name, "_tgt"}, lkp_target, vecs[i].exp_target);
      check({vecs[i].name, "_busy"}, 32'(busy), 32'd0);
      tick();
      idle_inputs();
    end

`ifdef BTB_STATS_EN
    check("stat_evicts", stat_evicts, 32'd1);
    check("stat_hits", stat_hits, 32'd4);
`endif

    // Fill entries 0, 31 and 63, then sweep; an update at observed cycle 40
    // targets index 16, which the sweep has already passed.
    train(32'h0040_0000, 32'h0040_0A00);
    train(32'h0040_007C, 32'h0040_0A7C);
    train(32'h0040_00FC, 32'h0040_0AFC);
    probe("fill0",  32'h0040_0000, 1'b1, 32'h0040_0A00);
    probe("fill31", 32'h0040_007C, 1'b1, 32'h0040_0A7C);
    probe("fill63", 32'h0040_00FC, 1'b1, 32'h0040_0AFC);
    sweep("sweep1", 0, 40, 64);
    probe("post0",  32'h0040_0000, 1'b0, 32'h0);
    probe("post31", 32'h0040_007C, 1'b0, 32'h0);
    probe("post63", 32'h0040_00FC, 1'b0, 32'h0);
    probe("post_midupd", 32'h0040_0040, 1'b0, 32'h0);

    // Restart: flush again at observed cycle 10 -> 10 + 64 busy cycles.
    sweep("restart", 10, 0, 74);

    // Asynchronous reset at sweep cycle 20.
    train(32'h0040_00FC, 32'h0040_0BBB);
    probe("refill63", 32'h0040_00FC, 1'b1, 32'h0040_0BBB);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (19) tick();
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_busy", 32'(busy), 32'd0);
    probe("rst_async_lkp", 32'h0040_00FC, 1'b0, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    check("rst_rel_busy", 32'(busy), 32'd0);
    probe("rst_rel_lkp", 32'h0040_00FC, 1'b0, 32'h0);
    sweep("after_rst", 0, 0, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
